output_drain_buffer: RTL and testbench
======================================

Name: output_drain_buffer

Overview:
- Sits directly downstream of the convolution controller/MAC datapath.
- Captures each finished output pixel, meaning the accumulator value together with output_x, output_y and output_ch, on the single-cycle output_valid pulse.
- Holds captured pixels in a small FIFO and drains them to an external consumer over a valid/ready handshake.
- Provides a hold signal so the top level can gate a_valid/b_valid before the FIFO overflows. It also tracks end-of-layer completion.

Parameters:
- DATA_WIDTH, 32, width of one accumulated output value.
- FIFO_DEPTH, 8, number of entries; power of two, at least 2.
- HOLD_MARGIN, 2, hold asserts when free entries are at or below this value; must be less than FIFO_DEPTH.
- FEATURE_MAP_WIDTH, 1024, x extent of the layer.
- FEATURE_MAP_HEIGHT, 1024, y extent of the layer.
- OUTPUT_NB_CHANNELS, 64, number of output channels.

Ports:
- clk  in  1  clock.
- arst_n_in  in  1  asynchronous reset, active low.
- start  in  1  begin a layer; clears counters and flags.
- in_valid  in  1  one-cycle pulse marking a finished pixel (from output_valid).
- in_data  in  DATA_WIDTH  accumulator value.
- in_x  in  32  pixel x.
- in_y  in  32  pixel y.
- in_ch  in  32  output channel.
- hold  out  1  almost-full backpressure to the top level.
- out_valid  out  1  head entry available.
- out_ready  in  1  consumer accepts the head entry.
- out_data  out  DATA_WIDTH  head value.
- out_x  out  32  head pixel x.
- out_y  out  32  head pixel y.
- out_ch  out  32  head channel.
- out_last  out  1  head entry is the final pixel of the layer.
- fill_level  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- overflow  out  1  sticky: a pixel was dropped.
- done  out  1  all layer pixels drained.

Behaviour:
- Reset is asynchronous and active low. The single clock is clk and the reset is arst_n_in.
- Reset state and reset value of every output:
  - State is IDLE; FIFO is empty; all counters are 0.
  - hold=0, out_valid=0, out_data/out_x/out_y/out_ch=0, out_last=0, fill_level=0, overflow=0, done=0.
- Reset asserted mid-operation discards all FIFO contents immediately.
- TOTAL = FEATURE_MAP_WIDTH*FEATURE_MAP_HEIGHT*OUTPUT_NB_CHANNELS. Counters are 32 bits wide.
- State machine:
  - IDLE: in_valid is ignored (not stored, not flagged). On start, go to ACTIVE and clear push_cnt, overflow and done.
  - ACTIVE: push and pop are enabled. When the entry tagged last is popped (out_valid && out_ready && out_last), go to DONE.
  - DONE: done=1; in_valid is ignored. On start, go to ACTIVE with the same clearing as in IDLE.
  - start asserted while in ACTIVE is ignored.
- Push (ACTIVE only):
  - Condition: in_valid && (fill_level<FIFO_DEPTH || pop this cycle).
  - The entry stores data, x, y, ch and a last bit equal to (push_cnt==TOTAL-1).
  - push_cnt increments on each accepted push.
  - push_cnt saturates at TOTAL. Pushes beyond TOTAL are still accepted but tagged last=0.
- Drop:
  - Condition: in_valid in ACTIVE while fill_level==FIFO_DEPTH and no pop this cycle.
  - The pixel is discarded, overflow is set on the next edge, and push_cnt is not incremented.
  - overflow stays set until start.
- Pop:
  - Condition: out_valid && out_ready. The head advances on the edge.
  - out_* show the head entry combinationally from FIFO storage (show-ahead).
  - out_valid = (fill_level!=0), in ACTIVE or DONE.
- Latency: a pixel pushed at edge N is presented with out_valid=1 in the cycle after edge N. There is no bypass of an empty FIFO.
- Simultaneous push and pop: fill_level is unchanged. This holds even when the FIFO is full, where the push is accepted.
- fill_level updates on the edge as +1, -1 or 0.
- hold = (FIFO_DEPTH - fill_level) <= HOLD_MARGIN. It is registered-free (combinational from fill_level) and forced to 0 in IDLE.
- Pointers are $clog2(FIFO_DEPTH) bits and wrap naturally. Full/empty are decided by fill_level, not by pointer comparison.
- done is held at 1 until the next start or reset.

Test Plan:
Parameters for all scenarios: FIFO_DEPTH=4, HOLD_MARGIN=1, W=2, H=2, OC=2, so TOTAL=8.
1. Reset check: reset, then start, then 1 pulse (data=5, x=1, y=0, ch=1) with out_ready=0 -> out_valid=1 one cycle later with out_data=5, out_x=1, out_ch=1; fill_level=1; hold=0.
2. Fill and hold: 3 pushes with out_ready=0 -> fill_level=3, hold=1. A 4th push -> fill_level=4. A 5th push -> dropped, overflow=1 next cycle, fill_level stays 4.
3. Full with concurrent pop: FIFO full, in_valid and out_ready in the same cycle -> push accepted, fill_level stays 4, no overflow. The next head is the second-oldest entry.
4. Layer completion: 8 pulses, each followed by pops with out_ready=1 -> out_last=1 only on the 8th entry. done=1 the cycle after it is popped. A later in_valid is ignored.
5. Restart: start while in DONE -> done=0, overflow=0, push_cnt=0. 8 more pixels complete the layer again. A start pulse asserted mid-layer is ignored (fill_level and counters unaffected).
6. Reset mid-operation: FIFO holding 3 entries, assert arst_n_in=0 asynchronously -> out_valid=0, fill_level=0 and hold=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/output_drain_buffer.sv
// output_drain_buffer
// Captures finished output pixels from the MAC datapath into a small show-ahead
// FIFO and drains them to a consumer over valid/ready. hold is an almost-full
// warning for the upstream issue logic. The block also tracks end-of-layer
// completion by tagging the final pixel of the layer.
module output_drain_buffer #(
    parameter int DATA_WIDTH         = 32,
    parameter int FIFO_DEPTH         = 8,
    parameter int HOLD_MARGIN        = 2,
    parameter int FEATURE_MAP_WIDTH  = 1024,
    parameter int FEATURE_MAP_HEIGHT = 1024,
    parameter int OUTPUT_NB_CHANNELS = 64
) (
    input  logic                          clk,
    input  logic                          arst_n_in,
    input  logic                          start,
    input  logic                          in_valid,
    input  logic [DATA_WIDTH-1:0]         in_data,
    input  logic [31:0]                   in_x,
    input  logic [31:0]                   in_y,
    input  logic [31:0]                   in_ch,
    output logic                          hold,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic [31:0]                   out_x,
    output logic [31:0]                   out_y,
    output logic [31:0]                   out_ch,
    output logic                          out_last,
    output logic [$clog2(FIFO_DEPTH):0]   fill_level,
    output logic                          overflow,
    output logic                          done
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] MARGIN_C = CW'(HOLD_MARGIN);
    localparam logic [31:0]   TOTAL    = 32'(FEATURE_MAP_WIDTH * FEATURE_MAP_HEIGHT * OUTPUT_NB_CHANNELS);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_DONE   = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          fill_q, fill_d;
    logic [31:0]            push_cnt_q, push_cnt_d;
    logic                   overflow_q, overflow_d;

    // Entry storage, one slot per FIFO position.
    logic [DATA_WIDTH-1:0]  data_mem_q [FIFO_DEPTH];
    logic [31:0]            x_mem_q    [FIFO_DEPTH];
    logic [31:0]            y_mem_q    [FIFO_DEPTH];
    logic [31:0]            ch_mem_q   [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]  last_mem_q;

    logic                   pop_s;
    logic                   push_s;
    logic                   drop_s;
    logic                   start_ok_s;
    logic                   last_tag_s;

    // Handshake qualifiers. Push is allowed into a full FIFO when the head
    // leaves in the same cycle; otherwise a pixel arriving at full is dropped.
    assign out_valid  = (fill_q != {CW{1'b0}}) && (state_q != S_IDLE);
    assign pop_s      = out_valid && out_ready;
    assign push_s     = (state_q == S_ACTIVE) && in_valid && ((fill_q < DEPTH_C) || pop_s);
    assign drop_s     = (state_q == S_ACTIVE) && in_valid && (fill_q == DEPTH_C) && !pop_s;
    assign start_ok_s = start && (state_q != S_ACTIVE);
    assign last_tag_s = (push_cnt_q == (TOTAL - 32'd1));

    // Show-ahead head entry and status outputs.
    assign out_data   = data_mem_q[rd_ptr_q];
    assign out_x      = x_mem_q[rd_ptr_q];
    assign out_y      = y_mem_q[rd_ptr_q];
    assign out_ch     = ch_mem_q[rd_ptr_q];
    assign out_last   = last_mem_q[rd_ptr_q];
    assign fill_level = fill_q;
    assign overflow   = overflow_q;
    assign done       = (state_q == S_DONE);
    assign hold       = (state_q != S_IDLE) && ((DEPTH_C - fill_q) <= MARGIN_C);

    // Layer state machine: next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ACTIVE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACTIVE: begin
                if (pop_s && out_last) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_ACTIVE;
                end
            end
            S_DONE: begin
                if (start) begin
                    state_d = S_ACTIVE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Pointer, occupancy, pixel counter and overflow next-state logic.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fill_d     = fill_q;
        push_cnt_d = push_cnt_q;
        overflow_d = overflow_q;

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PW'(1'b1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1'b1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   fill_d = fill_q + CW'(1'b1);
            2'b01:   fill_d = fill_q - CW'(1'b1);
            default: fill_d = fill_q;
        endcase

        // push_cnt saturates at TOTAL so extra pixels never re-tag last.
        if (start_ok_s) begin
            push_cnt_d = 32'd0;
        end else if (push_s && (push_cnt_q != TOTAL)) begin
            push_cnt_d = push_cnt_q + 32'd1;
        end else begin
            push_cnt_d = push_cnt_q;
        end

        if (start_ok_s) begin
            overflow_d = 1'b0;
        end else if (drop_s) begin
            overflow_d = 1'b1;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Control state registers; reset empties the FIFO immediately.
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= {PW{1'b0}};
            rd_ptr_q   <= {PW{1'b0}};
            fill_q     <= {CW{1'b0}};
            push_cnt_q <= 32'd0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fill_q     <= fill_d;
            push_cnt_q <= push_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    // Entry storage write; cleared on reset so the head reads as zero.
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                data_mem_q[i] <= {DATA_WIDTH{1'b0}};
                x_mem_q[i]    <= 32'd0;
                y_mem_q[i]    <= 32'd0;
                ch_mem_q[i]   <= 32'd0;
            end
            last_mem_q <= {FIFO_DEPTH{1'b0}};
        end else if (push_s) begin
            data_mem_q[wr_ptr_q] <= in_data;
            x_mem_q[wr_ptr_q]    <= in_x;
            y_mem_q[wr_ptr_q]    <= in_y;
            ch_mem_q[wr_ptr_q]   <= in_ch;
            last_mem_q[wr_ptr_q] <= last_tag_s;
        end else begin
            last_mem_q <= last_mem_q;
        end
    end

endmodule

// File: tb/tb_output_drain_buffer.sv
// Directed self-checking bench for output_drain_buffer with a 4-deep FIFO,
// hold margin 1 and a 2x2x2 layer (8 pixels per layer).
module tb_output_drain_buffer;

    localparam int DW = 32;
    localparam int DEPTH = 4;
    localparam int CW = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          arst_n_in;
    logic          start;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic [31:0]   in_x, in_y, in_ch;
    logic          hold;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [31:0]   out_x, out_y, out_ch;
    logic          out_last;
    logic [CW-1:0] fill_level;
    logic          overflow;
    logic          done;

    int checks = 0;
    int errors = 0;

    output_drain_buffer #(
        .DATA_WIDTH        (DW),
        .FIFO_DEPTH        (DEPTH),
        .HOLD_MARGIN       (1),
        .FEATURE_MAP_WIDTH (2),
        .FEATURE_MAP_HEIGHT(2),
        .OUTPUT_NB_CHANNELS(2)
    ) dut (
        .clk       (clk),
        .arst_n_in (arst_n_in),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_x      (in_x),
        .in_y      (in_y),
        .in_ch     (in_ch),
        .hold      (hold),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_x     (out_x),
        .out_y     (out_y),
        .out_ch    (out_ch),
        .out_last  (out_last),
        .fill_level(fill_level),
        .overflow  (overflow),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] d, input logic [31:0] x, input logic [31:0] y, input logic [31:0] c);
        in_valid = 1'b1;
        in_data  = d;
        in_x     = x;
        in_y     = y;
        in_ch    = c;
        step();
        in_valid = 1'b0;
    endtask

    task automatic pop();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic reset_dut();
        arst_n_in = 1'b0;
        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = 32'd0;
        in_x      = 32'd0;
        in_y      = 32'd0;
        in_ch     = 32'd0;
        #7;
        arst_n_in = 1'b1;
        step();
    endtask

    initial begin
        // Reset values.
        reset_dut();
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_fill", fill_level, 3'd0);
        check_eq("rst_hold", hold, 1'b0);
        check_eq("rst_overflow", overflow, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_out_data", out_data, 32'd0);
        check_eq("rst_out_last", out_last, 1'b0);

        // In IDLE a pixel is ignored.
        push(32'hAA, 32'd0, 32'd0, 32'd0);
        check_eq("idle_ignore_fill", fill_level, 3'd0);
        check_eq("idle_ignore_ovf", overflow, 1'b0);

        // 1: single pixel appears the cycle after the push.
        pulse_start();
        check_eq("s1_empty_valid", out_valid, 1'b0);
        push(32'd5, 32'd1, 32'd0, 32'd1);
        check_eq("s1_out_valid", out_valid, 1'b1);
        check_eq("s1_out_data", out_data, 32'd5);
        check_eq("s1_out_x", out_x, 32'd1);
        check_eq("s1_out_y", out_y, 32'd0);
        check_eq("s1_out_ch", out_ch, 32'd1);
        check_eq("s1_fill", fill_level, 3'd1);
        check_eq("s1_hold", hold, 1'b0);

        // 2: fill up, hold at 3, full at 4, fifth dropped.
        push(32'h11, 32'd0, 32'd1, 32'd0);
        check_eq("s2_hold_at2", hold, 1'b0);
        push(32'h12, 32'd1, 32'd1, 32'd0);
        check_eq("s2_fill3", fill_level, 3'd3);
        check_eq("s2_hold3", hold, 1'b1);
        push(32'h13, 32'd0, 32'd0, 32'd1);
        check_eq("s2_fill4", fill_level, 3'd4);
        check_eq("s2_ovf_before", overflow, 1'b0);
        push(32'h14, 32'd1, 32'd0, 32'd1);
        check_eq("s2_overflow", overflow, 1'b1);
        check_eq("s2_fill_after_drop", fill_level, 3'd4);
        check_eq("s2_head_kept", out_data, 32'd5);

        // 3: full FIFO with concurrent push and pop.
        reset_dut();
        pulse_start();
        for (int i = 0; i < 4; i++) push(32'h20 + 32'(i), 32'(i), 32'd0, 32'd0);
        check_eq("s3_full", fill_level, 3'd4);
        out_ready = 1'b1;
        push(32'h24, 32'd4, 32'd0, 32'd0);
        out_ready = 1'b0;
        check_eq("s3_fill_same", fill_level, 3'd4);
        check_eq("s3_no_overflow", overflow, 1'b0);
        check_eq("s3_next_head", out_data, 32'h21);
        check_eq("s3_next_head_x", out_x, 32'd1);
        for (int i = 1; i < 5; i++) begin
            check_eq("s3_drain_order", out_data, 32'h20 + 32'(i));
            pop();
        end
        check_eq("s3_drained", fill_level, 3'd0);

        // 4: full layer, last only on the 8th entry, then DONE.
        reset_dut();
        pulse_start();
        for (int i = 0; i < 8; i++) begin
            push(32'h100 + 32'(i), 32'(i % 2), 32'((i / 2) % 2), 32'(i / 4));
            check_eq("s4_valid", out_valid, 1'b1);
            check_eq("s4_data", out_data, 32'h100 + 32'(i));
            check_eq("s4_last", out_last, (i == 7) ? 1'b1 : 1'b0);
            check_eq("s4_done_before", done, 1'b0);
            pop();
            check_eq("s4_fill_after_pop", fill_level, 3'd0);
        end
        check_eq("s4_done", done, 1'b1);
        check_eq("s4_valid_after", out_valid, 1'b0);
        push(32'h1FF, 32'd0, 32'd0, 32'd0);
        check_eq("s4_ignore_fill", fill_level, 3'd0);
        check_eq("s4_ignore_valid", out_valid, 1'b0);
        check_eq("s4_done_held", done, 1'b1);

        // 5: restart from DONE, overflow, mid-layer start ignored.
        pulse_start();
        check_eq("s5_done_clear", done, 1'b0);
        for (int i = 0; i < 4; i++) push(32'h200 + 32'(i), 32'd0, 32'd0, 32'd0);
        push(32'h2FF, 32'd0, 32'd0, 32'd0);
        check_eq("s5_overflow", overflow, 1'b1);
        for (int i = 0; i < 4; i++) begin
            check_eq("s5_last_early", out_last, 1'b0);
            pop();
        end
        pulse_start();
        check_eq("s5_mid_start_fill", fill_level, 3'd0);
        check_eq("s5_mid_start_ovf", overflow, 1'b1);
        check_eq("s5_mid_start_done", done, 1'b0);
        for (int i = 4; i < 8; i++) push(32'h200 + 32'(i), 32'd1, 32'd1, 32'd1);
        check_eq("s5_full", fill_level, 3'd4);
        for (int i = 4; i < 8; i++) begin
            check_eq("s5_data", out_data, 32'h200 + 32'(i));
            check_eq("s5_last", out_last, (i == 7) ? 1'b1 : 1'b0);
            pop();
        end
        check_eq("s5_done", done, 1'b1);
        pulse_start();
        check_eq("s5_restart_done", done, 1'b0);
        check_eq("s5_restart_ovf", overflow, 1'b0);

        // 6: asynchronous reset mid-operation.
        for (int i = 0; i < 3; i++) push(32'h300 + 32'(i), 32'd0, 32'd0, 32'd0);
        check_eq("s6_fill3", fill_level, 3'd3);
        check_eq("s6_hold3", hold, 1'b1);
        #2;
        arst_n_in = 1'b0;
        #1;
        check_eq("s6_async_valid", out_valid, 1'b0);
        check_eq("s6_async_fill", fill_level, 3'd0);
        check_eq("s6_async_hold", hold, 1'b0);
        check_eq("s6_async_data", out_data, 32'd0);
        #3;
        arst_n_in = 1'b1;
        step();
        check_eq("s6_idle_after", done, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
